fill_readout_sequencer: RTL and testbench

Sequences the readout of one stored ADC fill in response to a RD_FILL command accepted by the command processor. It pops one header word from the ADC header FIFO and streams a response frame onto the 32-bit AXI4-stream TX path. The frame is CSN echo, response CC, header, then N data words fetched from the ADC data memory. It owns the data-memory read port and the circular read pointer, and hides the memory's 2-cycle read latency behind a small credit-managed output buffer.

---
 rtl/fill_readout_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fill_readout_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_readout_sequencer.sv
// Streams one stored ADC fill as an AXIS response frame (CSN, CC, header, N data words).
// Memory read latency is hidden behind a credit-managed output buffer shared by all frame words.
module fill_readout_sequencer #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned BUF_DEPTH   = 4,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_csn,
  input  logic [31:0]       cmd_cc,
  output logic              busy,
  output logic [31:0]       tx_data,
  output logic [0:3]        tx_tkeep,
  output logic              tx_tvalid,
  output logic              tx_tlast,
  input  logic              tx_tready,
  output logic [ADDR_W-1:0] ADC_data_mem_addrb,
  input  logic [31:0]       ADC_data_mem_doutb,
  output logic              ADC_header_fifo_rd_en,
  input  logic [31:0]       ADC_header_fifo_dout,
  input  logic              ADC_header_fifo_empty,
  output logic [31:0]       fills_read,
  output logic [ADDR_W-1:0] rd_ptr
);

  localparam int unsigned IdxW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [2:0] {StIdle, StCheck, StSendCsn, StSendCc, StSendHdr, StData} state_e;

  state_e                state;
  logic [31:0]           csn_q, cc_q, hdr_q, fills_q;
  logic [ADDR_W-1:0]     n_q, issued_q, addr_q, ptr_q;
  logic                  err_q, rd_en_q;
  logic [31:0]           buf_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  buf_last;
  logic [IdxW-1:0]       wr_idx, rd_idx, wr_next, rd_next;
  logic [CntW-1:0]       occ;
  logic [MEM_LATENCY:0]  pipe_vld, pipe_last;

  logic                  pop, push, push_last, hdr_push, hdr_last, issue, tlast_pop;
  logic [31:0]           push_word, hdr_word;
  logic [1:0]            hdr_rem;
  logic [7:0]            inflight, credit;

  // hdr_rem reserves buffer slots for header words not yet pushed, so header pushes never stall
  // and data issued from SEND_CSN onward always lands behind the header.
  always_comb begin
    hdr_push = 1'b0;
    hdr_word = '0;
    hdr_last = 1'b0;
    hdr_rem  = 2'd0;
    unique case (state)
      StSendCsn: begin
        hdr_push = 1'b1;
        hdr_word = csn_q;
        hdr_rem  = 2'd3;
      end
      StSendCc: begin
        hdr_push = 1'b1;
        hdr_word = cc_q | 32'h8000_0000 | (err_q ? 32'h4000_0000 : 32'h0);
        hdr_last = err_q;
        hdr_rem  = 2'd2;
      end
      StSendHdr: begin
        hdr_push = 1'b1;
        hdr_word = hdr_q;
        hdr_last = (n_q == '0);
        hdr_rem  = 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= int'(MEM_LATENCY); i++) inflight = inflight + 8'(pipe_vld[i]);
    pop       = (occ != '0) && tx_tready;
    tlast_pop = pop && buf_last[rd_idx];
    push      = hdr_push || pipe_vld[MEM_LATENCY];
    push_word = hdr_push ? hdr_word : ADC_data_mem_doutb;
    push_last = hdr_push ? hdr_last : pipe_last[MEM_LATENCY];
    credit    = 8'(occ) + inflight + 8'(hdr_rem) - 8'(pop);
    issue     = (state inside {StSendCsn, StSendCc, StSendHdr, StData}) && !err_q &&
                (issued_q != n_q) && (credit < 8'(BUF_DEPTH));
    wr_next   = (wr_idx == IdxW'(BUF_DEPTH - 1)) ? '0 : wr_idx + 1'b1;
    rd_next   = (rd_idx == IdxW'(BUF_DEPTH - 1)) ? '0 : rd_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      csn_q     <= '0;
      cc_q      <= '0;
      hdr_q     <= '0;
      n_q       <= '0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      issued_q  <= '0;
      addr_q    <= '0;
      ptr_q     <= '0;
      fills_q   <= '0;
      pipe_vld  <= '0;
      pipe_last <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      occ       <= '0;
    end else begin
      rd_en_q <= 1'b0;
      unique case (state)
        StIdle: if (cmd_valid) begin
          csn_q <= cmd_csn;
          cc_q  <= cmd_cc;
          state <= StCheck;
        end
        StCheck: begin
          err_q    <= ADC_header_fifo_empty;
          rd_en_q  <= !ADC_header_fifo_empty;
          hdr_q    <= ADC_header_fifo_dout;
          n_q      <= ADC_header_fifo_empty ? '0 : ADC_header_fifo_dout[ADDR_W-1:0];
          issued_q <= '0;
          state    <= StSendCsn;
        end
        StSendCsn: state <= StSendCc;
        StSendCc:  state <= err_q ? StData : StSendHdr;
        StSendHdr: state <= StData;
        StData: if (tlast_pop) begin
          if (!err_q) fills_q <= fills_q + 32'd1;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase

      if (issue) begin
        addr_q   <= ptr_q;
        ptr_q    <= ptr_q + 1'b1;
        issued_q <= issued_q + 1'b1;
      end
      pipe_vld  <= {pipe_vld[MEM_LATENCY-1:0], issue};
      pipe_last <= {pipe_last[MEM_LATENCY-1:0], issue && (issued_q == n_q - 1'b1)};

      if (push) wr_idx <= wr_next;
      if (pop)  rd_idx <= rd_next;
      occ <= occ + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_idx] <= push_word;
      buf_last[wr_idx] <= push_last;
    end
  end

  assign cmd_ready             = (state == StIdle) && !reset;
  assign busy                  = (state != StIdle);
  assign tx_tvalid             = (occ != '0);
  assign tx_data               = tx_tvalid ? buf_data[rd_idx] : '0;
  assign tx_tlast              = tx_tvalid && buf_last[rd_idx];
  assign tx_tkeep              = 4'b1111;
  assign ADC_data_mem_addrb    = addr_q;
  assign ADC_header_fifo_rd_en = rd_en_q;
  assign fills_read            = fills_q;
  assign rd_ptr                = ptr_q;

endmodule

// File: tb/tb_fill_readout_sequencer.sv
// Directed bench for fill_readout_sequencer: memory returns its own address, frames are
// recorded by a negedge monitor and compared with hand-built expected frames.
module tb_fill_readout_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_csn = '0, cmd_cc = '0;
  logic        busy;
  logic [31:0] tx_data;
  logic [0:3]  tx_tkeep;
  logic        tx_tvalid, tx_tlast;
  logic        tx_tready = 1'b1;
  logic [11:0] addrb;
  logic [31:0] doutb = '0, mem_p1 = '0;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fills_read;
  logic [11:0] rd_ptr;

  int n_tests = 0, n_fail = 0;
  int rd_en_cnt = 0, stall_viol = 0, busy_viol = 0, bound_viol = 0;
  logic        rnd_mode = 1'b0;
  logic [15:0] lfsr = 16'hACE1;
  int          cyc = 0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic        stall_prev = 1'b0, tlast_prev = 1'b0;
  logic [32:0] stall_word = '0;

  fill_readout_sequencer dut (
    .clk                   (clk),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_csn               (cmd_csn),
    .cmd_cc                (cmd_cc),
    .busy                  (busy),
    .tx_data               (tx_data),
    .tx_tkeep              (tx_tkeep),
    .tx_tvalid             (tx_tvalid),
    .tx_tlast              (tx_tlast),
    .tx_tready             (tx_tready),
    .ADC_data_mem_addrb    (addrb),
    .ADC_data_mem_doutb    (doutb),
    .ADC_header_fifo_rd_en (fifo_rd_en),
    .ADC_header_fifo_dout  (fifo_dout),
    .ADC_header_fifo_empty (fifo_empty),
    .fills_read            (fills_read),
    .rd_ptr                (rd_ptr)
  );

  always #5 clk = ~clk;

  // Two-cycle read latency memory whose contents equal the address.
  always @(posedge clk) begin
    mem_p1 <= {20'h0, addrb};
    doutb  <= mem_p1;
  end

  always @(posedge clk) if (!reset && fifo_rd_en) rd_en_cnt++;

  // tready: all ones, or pseudo-random with a forced 5-cycle stall every 16 cycles.
  always @(posedge clk) begin
    #1;
    cyc++;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    if (!rnd_mode) tx_tready = 1'b1;
    else if ((cyc % 16) >= 10 && (cyc % 16) < 15) tx_tready = 1'b0;
    else tx_tready = lfsr[0] | lfsr[3];
  end

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
      tlast_prev = 1'b0;
    end else begin
      if (stall_prev && !(tx_tvalid && {tx_tlast, tx_data} == stall_word)) stall_viol++;
      if (tlast_prev && !(!busy && cmd_ready)) busy_viol++;
      tlast_prev = tx_tvalid && tx_tready && tx_tlast;
      stall_prev = tx_tvalid && !tx_tready;
      stall_word = {tx_tlast, tx_data};
      if (tx_tvalid && tx_tready) got_q.push_back({tx_tlast, tx_data});
      if (int'(dut.occ) + int'(dut.inflight) > 4) bound_viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [31:0] csn, input logic [31:0] cc);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_csn   = csn;
    cmd_cc    = cc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int base, input int budget);
    int n = 0;
    while (!(got_q.size() > base && got_q[got_q.size() - 1][32]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check({tag, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int base);
    int len = got_q.size() - base;
    int idx = -1;
    check({tag, "_len"}, len, exp_q.size());
    for (int i = 0; i < len && i < exp_q.size(); i++)
      if (idx < 0 && got_q[base + i] !== exp_q[i]) idx = i;
    if (idx < 0) idx = ((len < exp_q.size()) ? len : exp_q.size()) - 1;
    if (idx >= 0) check({tag, "_beat"}, got_q[base + idx], exp_q[idx]);
  endtask

  task automatic build_exp(input logic [31:0] csn, input logic [31:0] cc, input logic [31:0] hdr,
                           input int n, input int start);
    exp_q.delete();
    exp_q.push_back({1'b0, csn});
    exp_q.push_back({1'b0, cc | 32'h8000_0000});
    exp_q.push_back({n == 0, hdr});
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, 20'h0, 12'((start + i) % 4096)});
  endtask

  initial begin
    int base, rd0;
    logic [11:0] a0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_outs", {busy, tx_tvalid, tx_tlast, tx_data, fifo_rd_en}, 0);
    check("reset_regs", {addrb, rd_ptr, fills_read}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {cmd_ready, busy}, 2'b10);
    check("tkeep", tx_tkeep, 4'b1111);

    // 1: basic N=4 frame
    fifo_empty = 1'b0; fifo_dout = 32'h0000_0004;
    base = got_q.size(); rd0 = rd_en_cnt;
    send_cmd(32'h1000_0001, 32'h0000_0008);
    @(negedge clk);
    check("t1_busy", {busy, cmd_ready}, 2'b10);
    build_exp(32'h1000_0001, 32'h0000_0008, 32'h0000_0004, 4, 0);
    wait_frame("t1", base, 200);
    check_frame("t1", base);
    check("t1_rd_en", rd_en_cnt - rd0, 1);
    check("t1_fills", fills_read, 1);
    check("t1_rd_ptr", rd_ptr, 12'h004);

    // 2: empty header FIFO -> error frame
    fifo_empty = 1'b1;
    base = got_q.size(); rd0 = rd_en_cnt; a0 = addrb;
    send_cmd(32'h1000_0001, 32'h0000_0008);
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h1000_0001});
    exp_q.push_back({1'b1, 32'hC000_0008});
    wait_frame("t2", base, 200);
    check_frame("t2", base);
    check("t2_rd_en", rd_en_cnt - rd0, 0);
    check("t2_addrb", addrb, a0);
    check("t2_state", {fills_read, rd_ptr}, {32'd1, 12'h004});

    // 3: advance to 0xFFE, then wrap
    fifo_empty = 1'b0; fifo_dout = 32'h0000_0FFA;
    base = got_q.size();
    send_cmd(32'h2000_0000, 32'h0000_0008);
    build_exp(32'h2000_0000, 32'h0000_0008, 32'h0000_0FFA, 4090, 4);
    wait_frame("t3pre", base, 6000);
    check_frame("t3pre", base);
    check("t3pre_rd_ptr", rd_ptr, 12'hFFE);
    fifo_dout = 32'h0000_0004;
    base = got_q.size();
    send_cmd(32'h2000_0001, 32'h0000_0008);
    build_exp(32'h2000_0001, 32'h0000_0008, 32'h0000_0004, 4, 12'hFFE);
    wait_frame("t3", base, 200);
    check_frame("t3", base);
    check("t3_rd_ptr", rd_ptr, 12'h002);
    check("t3_fills", fills_read, 3);

    // 4: N=16 under random backpressure
    fifo_dout = 32'hA500_0010;
    base = got_q.size();
    rnd_mode = 1'b1;
    send_cmd(32'h3000_0001, 32'h0000_0008);
    build_exp(32'h3000_0001, 32'h0000_0008, 32'hA500_0010, 16, 2);
    wait_frame("t4", base, 1000);
    rnd_mode = 1'b0;
    check_frame("t4", base);
    check("t4_stall_hold", stall_viol, 0);
    check("t4_credit_bound", bound_viol, 0);
    check("t4_regs", {fills_read, rd_ptr}, {32'd4, 12'd18});

    // 5: N=0 header-only frame
    fifo_dout = 32'h5500_0000;
    base = got_q.size(); a0 = addrb;
    send_cmd(32'h4000_0001, 32'h0000_0009);
    build_exp(32'h4000_0001, 32'h0000_0009, 32'h5500_0000, 0, 0);
    wait_frame("t5", base, 200);
    check_frame("t5", base);
    check("t5_addrb", addrb, a0);
    check("t5_regs", {fills_read, rd_ptr}, {32'd5, 12'd18});

    // 6: reset during data phase of an N=8 frame
    fifo_dout = 32'h0000_0008;
    base = got_q.size();
    send_cmd(32'h5000_0001, 32'h0000_0008);
    for (int n = 0; n < 200 && got_q.size() < base + 5; n++) @(negedge clk);
    check("t6_progress", got_q.size() - base >= 5, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t6_cmd_ready_rst", cmd_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t6_outs", {tx_tvalid, tx_tlast, tx_data, busy, fifo_rd_en}, 0);
    check("t6_regs", {addrb, rd_ptr, fills_read}, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    base = got_q.size();
    repeat (6) @(negedge clk);
    check("t6_no_stale", got_q.size() - base, 0);
    fifo_dout = 32'h0000_0003;
    send_cmd(32'h6000_0001, 32'h0000_0008);
    build_exp(32'h6000_0001, 32'h0000_0008, 32'h0000_0003, 3, 0);
    wait_frame("t6", base, 200);
    check_frame("t6", base);
    check("t6_after", {fills_read, rd_ptr}, {32'd1, 12'd3});
    check("busy_fall_timing", busy_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
